// File: rtl/acc_exec_pkg.sv
// Shared definitions for the execute stage: data width, decoder one-hot bit
// positions and the execute FSM state encoding.
package acc_exec_pkg;

   localparam int ACC_W = 4;
   localparam int OP_N  = 8;

   // Bit positions in the decoder's one-hot control word (DI[0] = AND).
   localparam int AND_B  = 0;
   localparam int OR_B   = 1;
   localparam int XOR_B  = 2;
   localparam int SUMA_B = 3;
   localparam int INV_B  = 4;
   localparam int HOLD_B = 5;
   localparam int LOAD_B = 6;
   localparam int RST_B  = 7;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_DONE = 1'b1
   } state_t;

endpackage

// File: rtl/acc_alu.sv
// Combinational accumulator ALU: computes the next accumulator and flags for
// one decoded instruction. Unselected, disabled or illegal words return the
// current state unchanged; o_legal is low when more than one bit is set.
module acc_alu
   import acc_exec_pkg::*;
#(
   parameter int             W       = ACC_W,
   parameter logic [W-1:0]   ACC_RST = '0
) (
   input  logic [0:OP_N-1] i_op,
   input  logic [W-1:0]    i_acc,
   input  logic [W-1:0]    i_b,
   input  logic            i_c,
   input  logic            i_v,
   output logic [W-1:0]    o_acc,
   output logic            o_c,
   output logic            o_v,
   output logic            o_legal
);

   logic [W:0] w_sum;
   logic       w_legal;

   assign w_sum   = {1'b0, i_acc} + {1'b0, i_b};
   assign w_legal = $onehot0(i_op);
   assign o_legal = w_legal;

   // Next-state selection; defaults hold every register.
   always_comb begin
      o_acc = i_acc;
      o_c   = i_c;
      o_v   = i_v;
      if (w_legal) begin
         if (i_op[AND_B]) begin
            o_acc = i_acc & i_b;
         end else if (i_op[OR_B]) begin
            o_acc = i_acc | i_b;
         end else if (i_op[XOR_B]) begin
            o_acc = i_acc ^ i_b;
         end else if (i_op[SUMA_B]) begin
            o_acc = w_sum[W-1:0];
            o_c   = w_sum[W];
            o_v   = (i_acc[W-1] == i_b[W-1]) && (w_sum[W-1] != i_acc[W-1]);
         end else if (i_op[INV_B]) begin
            o_acc = ~i_acc;
         end else if (i_op[LOAD_B]) begin
            o_acc = i_b;
         end else if (i_op[RST_B]) begin
            o_acc = ACC_RST;
            o_c   = 1'b0;
            o_v   = 1'b0;
         end
      end
   end

endmodule

// File: rtl/acc_exec.sv
// Execute stage of the 4-bit processor: holds the accumulator, the carry,
// overflow and sticky error flags, and a two-state FSM that commits one
// instruction and reports it with a single-cycle done/busy pulse.
module acc_exec
   import acc_exec_pkg::*;
#(
   parameter int             W       = ACC_W,
   parameter logic [W-1:0]   ACC_RST = '0
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [0:OP_N-1] DI_i,
   input  logic [W-1:0]    dato_i,
   input  logic            valid_i,
   output logic            busy_o,
   output logic [W-1:0]    acc_o,
   output logic            c_o,
   output logic            z_o,
   output logic            v_o,
   output logic            err_o,
   output logic            done_o
);

   state_t       r_state;
   logic [W-1:0] r_acc;
   logic         r_c;
   logic         r_v;
   logic         r_err;
   logic         r_done;
   logic         r_busy;

   logic [W-1:0] w_acc;
   logic         w_c;
   logic         w_v;
   logic         w_legal;

   acc_alu #(
      .W       (W),
      .ACC_RST (ACC_RST)
   ) u_alu (
      .i_op    (DI_i),
      .i_acc   (r_acc),
      .i_b     (dato_i),
      .i_c     (r_c),
      .i_v     (r_v),
      .o_acc   (w_acc),
      .o_c     (w_c),
      .o_v     (w_v),
      .o_legal (w_legal)
   );

   // FSM plus datapath registers; results commit on the edge leaving IDLE.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_acc   <= ACC_RST;
         r_c     <= 1'b0;
         r_v     <= 1'b0;
         r_err   <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (valid_i) begin
                  r_acc   <= w_acc;
                  r_c     <= w_c;
                  r_v     <= w_v;
                  if (!w_legal) begin
                     r_err <= 1'b1;
                  end
                  r_done  <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_done  <= 1'b0;
                  r_busy  <= 1'b0;
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign acc_o  = r_acc;
   assign c_o    = r_c;
   assign v_o    = r_v;
   assign err_o  = r_err;
   assign done_o = r_done;
   assign busy_o = r_busy;
   assign z_o    = (r_acc == '0);

endmodule

// File: tb/tb_acc_exec.sv
// Self-checking bench for acc_exec: a reference model pushes expected results
// into a scoreboard as instructions are driven; a monitor pops and compares
// on every done_o pulse. Scenario tasks add direct checks of the documented
// values.
module tb_acc_exec;

   typedef struct packed {
      logic [3:0] acc;
      logic       c;
      logic       v;
      logic       z;
      logic       err;
   } exp_t;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [0:7] DI_i = '0;
   logic [3:0] dato_i = '0;
   logic       valid_i = 1'b0;
   logic       busy_o;
   logic [3:0] acc_o;
   logic       c_o, z_o, v_o, err_o, done_o;

   int checks = 0;
   int errors = 0;
   int n_done = 0;

   exp_t q[$];

   logic [3:0] m_acc = 4'h0;
   logic       m_c   = 1'b0;
   logic       m_v   = 1'b0;
   logic       m_err = 1'b0;

   acc_exec #(
      .W       (4),
      .ACC_RST (4'b0000)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .DI_i    (DI_i),
      .dato_i  (dato_i),
      .valid_i (valid_i),
      .busy_o  (busy_o),
      .acc_o   (acc_o),
      .c_o     (c_o),
      .z_o     (z_o),
      .v_o     (v_o),
      .err_o   (err_o),
      .done_o  (done_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [0:7] oh(input int idx);
      logic [0:7] d;
      d = '0;
      d[idx] = 1'b1;
      return d;
   endfunction

   // Reference model, written with integer arithmetic.
   task automatic model_apply(input logic [0:7] di, input logic [3:0] b);
      int ones;
      int s, sa, sb;
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(di[i]);
      if (ones > 1) begin
         m_err = 1'b1;
      end else if (ones == 1) begin
         if (di[0]) m_acc = m_acc & b;
         else if (di[1]) m_acc = m_acc | b;
         else if (di[2]) m_acc = m_acc ^ b;
         else if (di[3]) begin
            s  = int'(m_acc) + int'(b);
            sa = (m_acc > 4'd7) ? int'(m_acc) - 16 : int'(m_acc);
            sb = (b > 4'd7) ? int'(b) - 16 : int'(b);
            m_c = (s > 15);
            m_v = ((sa + sb) > 7) || ((sa + sb) < -8);
            m_acc = 4'(s % 16);
         end
         else if (di[4]) m_acc = ~m_acc;
         else if (di[6]) m_acc = b;
         else if (di[7]) begin
            m_acc = 4'h0;
            m_c   = 1'b0;
            m_v   = 1'b0;
         end
      end
   endtask

   task automatic push_expected(input logic [0:7] di, input logic [3:0] b);
      exp_t e;
      model_apply(di, b);
      e.acc = m_acc;
      e.c   = m_c;
      e.v   = m_v;
      e.z   = (m_acc == 4'h0);
      e.err = m_err;
      q.push_back(e);
   endtask

   // Drive one instruction from IDLE and return once the FSM is back in IDLE.
   task automatic send(input logic [0:7] di, input logic [3:0] b);
      @(negedge clk_i);
      valid_i = 1'b1;
      DI_i    = di;
      dato_i  = b;
      push_expected(di, b);
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      DI_i    = '0;
      @(posedge clk_i);
      #1;
   endtask

   // Scoreboard monitor: every done_o pulse must match the oldest expectation.
   initial begin
      exp_t e;
      logic prev_done;
      prev_done = 1'b0;
      forever begin
         @(posedge clk_i);
         #1;
         if (done_o === 1'b1) begin
            n_done++;
            checks++;
            if (prev_done === 1'b1) begin
               errors++;
               $display("FAIL done_width: done_o high two cycles in a row");
            end
            checks++;
            if (busy_o !== 1'b1) begin
               errors++;
               $display("FAIL sb_busy: busy_o=%b required 1", busy_o);
            end
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL sb_unexpected: done_o with no pending instruction");
            end else begin
               e = q.pop_front();
               if ({acc_o, c_o, v_o, z_o, err_o} !== e) begin
                  errors++;
                  $display("FAIL sb_result: acc=%h c=%b v=%b z=%b err=%b required acc=%h c=%b v=%b z=%b err=%b",
                           acc_o, c_o, v_o, z_o, err_o, e.acc, e.c, e.v, e.z, e.err);
               end
            end
         end
         prev_done = done_o;
      end
   end

   task automatic test_reset();
      #3;
      checks++;
      if ({acc_o, z_o, c_o, v_o, err_o, done_o, busy_o} !== {4'h0, 1'b1, 5'b0}) begin
         errors++;
         $display("FAIL reset_values: acc=%h z=%b c=%b v=%b err=%b done=%b busy=%b required 0 1 0 0 0 0 0",
                  acc_o, z_o, c_o, v_o, err_o, done_o, busy_o);
      end
      @(negedge clk_i);
      rst_i = 1'b0;
      send(oh(6), 4'h9);
      send(8'b00110000, 4'h0);
      // Enter DONE, then reset asynchronously mid-cycle.
      @(negedge clk_i);
      valid_i = 1'b1;
      DI_i    = oh(6);
      dato_i  = 4'h5;
      push_expected(oh(6), 4'h5);
      @(posedge clk_i);
      #1;
      valid_i = 1'b0;
      DI_i    = '0;
      #1;
      checks++;
      if (done_o !== 1'b1 || err_o !== 1'b1 || acc_o !== 4'h5) begin
         errors++;
         $display("FAIL pre_reset_done: done=%b err=%b acc=%h required 1 1 5", done_o, err_o, acc_o);
      end
      rst_i = 1'b1;
      #1;
      checks++;
      if ({acc_o, z_o, c_o, v_o, err_o, done_o, busy_o} !== {4'h0, 1'b1, 5'b0}) begin
         errors++;
         $display("FAIL async_reset: acc=%h z=%b c=%b v=%b err=%b done=%b busy=%b required 0 1 0 0 0 0 0",
                  acc_o, z_o, c_o, v_o, err_o, done_o, busy_o);
      end
      m_acc = 4'h0; m_c = 1'b0; m_v = 1'b0; m_err = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   task automatic test_logic();
      logic [3:0] want [5];
      logic [0:7] ops  [5];
      logic [3:0] bs   [5];
      int d0;
      ops = '{oh(6), oh(0), oh(1), oh(2), oh(4)};
      bs  = '{4'b1010, 4'b0110, 4'b1000, 4'b1111, 4'b0000};
      want = '{4'b1010, 4'b0010, 4'b1010, 4'b0101, 4'b1010};
      d0 = n_done;
      for (int i = 0; i < 5; i++) begin
         send(ops[i], bs[i]);
         checks++;
         if (acc_o !== want[i] || c_o !== 1'b0) begin
            errors++;
            $display("FAIL logic_op%0d: acc=%b c=%b required acc=%b c=0", i, acc_o, c_o, want[i]);
         end
      end
      checks++;
      if (n_done - d0 != 5) begin
         errors++;
         $display("FAIL logic_done_count: %0d required 5", n_done - d0);
      end
   endtask

   task automatic test_add();
      send(oh(6), 4'hF);
      send(oh(3), 4'h1);
      checks++;
      if ({acc_o, c_o, z_o, v_o} !== {4'h0, 1'b1, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL add_wrap: acc=%h c=%b z=%b v=%b required 0 1 1 0", acc_o, c_o, z_o, v_o);
      end
      send(oh(6), 4'h7);
      send(oh(3), 4'h1);
      checks++;
      if ({acc_o, c_o, z_o, v_o} !== {4'h8, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL add_overflow: acc=%h c=%b z=%b v=%b required 8 0 0 1", acc_o, c_o, z_o, v_o);
      end
   endtask

   task automatic test_hold_disabled();
      int d0;
      send(oh(6), 4'h3);
      d0 = n_done;
      send(oh(5), 4'hC);
      send(8'b00000000, 4'hA);
      checks++;
      if (acc_o !== 4'h3 || err_o !== 1'b0 || (n_done - d0) != 2) begin
         errors++;
         $display("FAIL hold_disabled: acc=%h err=%b pulses=%0d required 3 0 2", acc_o, err_o, n_done - d0);
      end
   endtask

   task automatic test_illegal_rst();
      send(8'b11000000, 4'h0);
      checks++;
      if (acc_o !== 4'h3 || err_o !== 1'b1) begin
         errors++;
         $display("FAIL illegal: acc=%h err=%b required 3 1", acc_o, err_o);
      end
      send(oh(7), 4'h6);
      checks++;
      if ({acc_o, c_o, v_o, err_o} !== {4'h0, 1'b0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL rst_instr: acc=%h c=%b v=%b err=%b required 0 0 0 1", acc_o, c_o, v_o, err_o);
      end
   endtask

   task automatic test_back_to_back();
      logic exp_done;
      @(negedge clk_i);
      valid_i = 1'b1;
      DI_i    = oh(3);
      dato_i  = 4'h1;
      push_expected(oh(3), 4'h1);
      push_expected(oh(3), 4'h1);
      for (int k = 0; k < 4; k++) begin
         @(posedge clk_i);
         #1;
         exp_done = (k % 2 == 0);
         checks++;
         if (done_o !== exp_done || busy_o !== exp_done) begin
            errors++;
            $display("FAIL b2b_cycle%0d: done=%b busy=%b required %b %b", k, done_o, busy_o, exp_done, exp_done);
         end
      end
      valid_i = 1'b0;
      DI_i    = '0;
      checks++;
      if (acc_o !== 4'h2) begin
         errors++;
         $display("FAIL b2b_acc: acc=%h required 2", acc_o);
      end
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      test_reset();
      test_logic();
      test_add();
      test_hold_disabled();
      test_illegal_rst();
      test_back_to_back();
      repeat (3) @(posedge clk_i);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d results never reported, required 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
